seq_cpu_core: RTL
=================

# seq_cpu_core

Multi-cycle, parametrised successor to the single-cycle combinational CPU. Accepts one instruction per valid/ready handshake, reads operands from an internal register file (or an immediate), executes one of eight ALU operations, writes the result back, and reports result plus zero/carry flags. It is the datapath core the future fetch/sequencer stage drives.

## Interface
Parameters:
- WIDTH, 8, data/operand width in bits (≥4).
- NREGS, 4, register-file depth (power of two, ≥2); AW = clog2(NREGS).
- INSTR_W, 4+2*AW+WIDTH, derived instruction width (not overridable).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- instr  input  INSTR_W  {op[2:0], imm_sel, rd[AW-1:0], ra[AW-1:0], b[WIDTH-1:0]}.
- instr_valid  input  1  instr is valid this cycle.
- instr_ready  output  1  core can accept an instruction.
- result  output  WIDTH  last executed result; holds until next writeback.
- result_valid  output  1  one-cycle pulse when result/flags update.
- flag_z  output  1  result == 0.
- flag_c  output  1  carry/borrow/shift-out of last op.
- busy  output  1  state ≠ IDLE.

## Operation
- Opcodes: 000 ADD a+b; 001 SUB a−b; 010 AND; 011 OR; 100 XOR; 101 NOT a (b ignored); 110 SHL a by 1; 111 SHR a by 1 (logical).
- a = R[ra]. b = imm_sel ? instr.b : R[instr.b[AW-1:0]] (upper bits of b ignored in register mode).
- Arithmetic modulo 2^WIDTH. flag_c: ADD carry-out; SUB borrow (1 when a<b unsigned); SHL old a[WIDTH-1]; SHR old a[0]; logic ops and NOT clear it. flag_z = (result == 0) for every op.
- Every op writes R[rd]; rd may equal ra/rb (source read happens before write).
- FSM: IDLE → EXEC on accept (instr_valid & instr_ready): latch instr fields. EXEC → WB unconditionally: read regfile, compute ALU result and carry into pipeline registers. WB → IDLE unconditionally: write R[rd], update result/flag_z/flag_c, assert result_valid.
- instr_ready = (state == IDLE). instr and instr_valid ignored outside IDLE; no buffering.
- No RAW hazard possible: next instruction accepted only after writeback.

## Timing
- Accept at edge k; EXEC during cycle k..k+1; WB edge k+2 commits register and outputs; result_valid high for cycle after edge k+2 only.
- instr_ready high again in that same cycle; back-to-back throughput one instruction per 3 cycles.
- Reset values (any rst_n=0 edge): state IDLE, all R[i]=0, result=0, result_valid=0, flag_z=0, flag_c=0, busy=0, instr_ready=1 the cycle after reset releases (0 while rst_n low).
- Reset mid-operation (EXEC or WB): instruction dropped, no register write, no result_valid pulse.
- instr_valid held high continuously: a new instruction accepted every IDLE cycle.

## Structure
- Package seq_cpu_pkg: opcode enum (OP_ADD..OP_SHR), FSM state enum (IDLE, EXEC, WB), function alu_eval(op, a, b) returning {carry, result} parametrised via WIDTH argument.
- Sub-module cpu_regfile: NREGS×WIDTH, two async read ports, one sync write port, synchronous active-low clear.
- Top holds FSM, instruction latch, ALU result/carry pipeline registers, output registers.

## Test plan
- Reset: drive rst_n=0 two cycles with instr_valid=1 → all outputs 0, instr_ready 0; release → instr_ready=1, no write occurred (later read shows R0..R3 = 0).
- Immediate ADD then register ADD (WIDTH=8): ADD imm R1=0+0xF0, ADD imm R2=0+0x20, ADD reg R3=R1+R2 → result 0x10, flag_c=1, flag_z=0, result_valid exactly 3 cycles after each accept.
- SUB borrow/zero: R1=0x05, SUB imm 0x05 → result 0, z=1, c=0; SUB imm 0x06 → 0xFF, z=0, c=1.
- Shifts/logic: R1=0x81, SHL → 0x02, c=1; SHR on 0x81 → 0x40, c=1; XOR imm 0xFF on 0x40 → 0xBF, c=0; NOT → 0x40.
- Handshake: instr_valid held high with changing instr → instr_ready only in IDLE, instructions presented during EXEC/WB ignored, accept cadence every 3 cycles.
- Reset mid-op: assert rst_n=0 in EXEC of ADD imm R1=0x33 → no result_valid, R1 reads 0 afterwards; repeat with WIDTH=16, NREGS=8 for a 0xFFFF+1 ADD → result 0, z=1, c=1.

Source files
------------

// File: rtl/seq_cpu_pkg.sv
// seq_cpu_pkg: opcodes, FSM states and the width-generic ALU
// shared by the multi-cycle datapath core.
package seq_cpu_pkg;

  localparam int MAXW = 64;

  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR,
    OP_XOR, OP_NOT, OP_SHL, OP_SHR
  } op_e;

  typedef enum logic [1:0] {
    IDLE, EXEC, WB
  } state_e;

  // Returns {carry, result}; operands must be zero-extended from w bits.
  function automatic logic [MAXW:0] alu_eval(
    input op_e              op,
    input logic [MAXW-1:0]  a,
    input logic [MAXW-1:0]  b,
    input int               w
  );
    logic [MAXW:0] ea;
    logic [MAXW:0] eb;
    logic [MAXW:0] s;
    logic [MAXW:0] m;
    logic          c;
    ea = {1'b0, a};
    eb = {1'b0, b};
    m  = {1'b0, {MAXW{1'b1}}} >> (MAXW - w);
    c  = 1'b0;
    s  = '0;
    unique case (op)
      OP_ADD: begin
        s = ea + eb;
        c = s[w];
      end
      OP_SUB: begin
        s = ea - eb;
        c = (a < b);
      end
      OP_AND: s = ea & eb;
      OP_OR:  s = ea | eb;
      OP_XOR: s = ea ^ eb;
      OP_NOT: s = ~ea;
      OP_SHL: begin
        s = ea << 1;
        c = a[w-1];
      end
      OP_SHR: begin
        s = ea >> 1;
        c = a[0];
      end
    endcase
    s = s & m;
    return {c, s[MAXW-1:0]};
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// cpu_regfile: NREGS x WIDTH register file, two async read
// ports, one sync write port, synchronous active-low clear.
module cpu_regfile
  import seq_cpu_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREGS = 4,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    addr_a,
  input  logic [AW-1:0]    addr_b,
  output logic [WIDTH-1:0] data_a,
  output logic [WIDTH-1:0] data_b,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data
);

  logic [WIDTH-1:0] mem [NREGS];

  assign data_a = mem[addr_a];
  assign data_b = mem[addr_b];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/seq_cpu_core.sv
// seq_cpu_core: multi-cycle IDLE/EXEC/WB datapath core with
// register file, eight-op ALU and zero/carry flags.
module seq_cpu_core
  import seq_cpu_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int NREGS   = 4,
  localparam int AW      = $clog2(NREGS),
  localparam int INSTR_W = 4 + 2 * AW + WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [WIDTH-1:0]   result,
  output logic               result_valid,
  output logic               flag_z,
  output logic               flag_c,
  output logic               busy
);

  state_e           state;
  op_e              op_q;
  logic             imm_q;
  logic [AW-1:0]    rd_q;
  logic [AW-1:0]    ra_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;

  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic [WIDTH-1:0] opnd_b;
  logic [MAXW:0]    alu_out;
  logic             unused_alu;

  assign instr_ready = rst_n && (state == IDLE);
  assign busy        = (state != IDLE);

  // Register mode uses only the low AW bits of b as index.
  assign opnd_b  = imm_q ? b_q : data_b;
  assign alu_out = alu_eval(op_q, MAXW'(data_a),
                            MAXW'(opnd_b), WIDTH);
  assign unused_alu = ^alu_out[MAXW-1:WIDTH];

  cpu_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr_a  (ra_q),
    .addr_b  (b_q[AW-1:0]),
    .data_a  (data_a),
    .data_b  (data_b),
    .wr_en   (state == WB),
    .wr_addr (rd_q),
    .wr_data (alu_res)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      op_q         <= OP_ADD;
      imm_q        <= 1'b0;
      rd_q         <= '0;
      ra_q         <= '0;
      b_q          <= '0;
      alu_res      <= '0;
      alu_c        <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      flag_z       <= 1'b0;
      flag_c       <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (instr_valid) begin
            op_q  <= op_e'(instr[INSTR_W-1 -: 3]);
            imm_q <= instr[INSTR_W-4];
            rd_q  <= instr[WIDTH+2*AW-1 -: AW];
            ra_q  <= instr[WIDTH+AW-1 -: AW];
            b_q   <= instr[WIDTH-1:0];
            state <= EXEC;
          end
        end
        EXEC: begin
          alu_res <= alu_out[WIDTH-1:0];
          alu_c   <= alu_out[MAXW];
          state   <= WB;
        end
        WB: begin
          result       <= alu_res;
          flag_z       <= (alu_res == '0);
          flag_c       <= alu_c;
          result_valid <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
